// File: rtl/key_event_pkg.sv
// Shared definitions for the key event decoder: per-key state encoding,
// key index constants and the hold-counter width helper.
package key_event_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        LONG = 2'd2
    } key_state_e;

    localparam int KEY_MODE   = 0;
    localparam int KEY_MOVE   = 1;
    localparam int KEY_ADD    = 2;
    localparam int KEY_SWITCH = 3;

    // Counter only ever reaches max-1, so clog2 of the larger period suffices.
    function automatic int cnt_width(input int long_time, input int repeat_time);
        int m;
        m = (long_time > repeat_time) ? long_time : repeat_time;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/key_event_fsm.sv
// One key's sample stages, press/hold/long FSM and hold counter.
// Auto-repeat in the LONG state is only built when KEY_REPEAT_EN is defined.
module key_event_fsm
    import key_event_pkg::*;
#(
    parameter int   LONG_TIME   = 50_000_000,
    parameter int   REPEAT_TIME = 10_000_000,
    parameter logic REPEAT_ON   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic busy
);

    localparam int CW = cnt_width(LONG_TIME, REPEAT_TIME);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TIME - 1);

    logic          d1_q, d2_q;
    logic          fall, rise;
    key_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          busy_q, busy_d;

    assign fall = d2_q & ~d1_q;
    assign rise = ~d2_q & d1_q;

`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_TIME - 1);
    logic repeat_q, repeat_d;
`else
    logic unused_repeat_on;
    assign unused_repeat_on = REPEAT_ON;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
`ifdef KEY_REPEAT_EN
        repeat_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (fall) begin
                    press_d = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // A release on the terminal-count cycle wins over long_pulse.
                if (rise) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = LONG;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LONG: begin
                if (rise) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
`ifdef KEY_REPEAT_EN
                    if (REPEAT_ON) begin
                        if (cnt_q == REP_LAST) begin
                            repeat_d = 1'b1;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Sample stages reset to the released level so a key held through reset
    // is seen as a fresh press afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d1_q      <= 1'b1;
            d2_q      <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef KEY_REPEAT_EN
            repeat_q  <= 1'b0;
`endif
        end else begin
            d1_q      <= key_n;
            d2_q      <= d1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            busy_q    <= busy_d;
`ifdef KEY_REPEAT_EN
            repeat_q  <= repeat_d;
`endif
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign busy          = busy_q;
`ifdef KEY_REPEAT_EN
    assign repeat_pulse  = repeat_q;
`else
    assign repeat_pulse  = 1'b0;
`endif

endmodule

// File: rtl/key_event_decoder.sv
// Turns the four debounced active-low key levels into press/release/long/repeat
// pulses. Auto-repeat (gated per key by REPEAT_MASK) requires KEY_REPEAT_EN.
module key_event_decoder
    import key_event_pkg::*;
#(
    parameter int         LONG_TIME   = 50_000_000,
    parameter int         REPEAT_TIME = 10_000_000,
    parameter logic [3:0] REPEAT_MASK = 4'b0100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       filter_mode_key,
    input  logic       filter_move_key,
    input  logic       filter_add_key,
    input  logic       filter_switch_key,
    output logic [3:0] press_pulse,
    output logic [3:0] release_pulse,
    output logic [3:0] long_pulse,
    output logic [3:0] repeat_pulse,
    output logic       key_busy
);

    logic [3:0] key_n;
    logic [3:0] busy;

    assign key_n[KEY_MODE]   = filter_mode_key;
    assign key_n[KEY_MOVE]   = filter_move_key;
    assign key_n[KEY_ADD]    = filter_add_key;
    assign key_n[KEY_SWITCH] = filter_switch_key;

    for (genvar gi = 0; gi < 4; gi++) begin : g_key
        key_event_fsm #(
            .LONG_TIME  (LONG_TIME),
            .REPEAT_TIME(REPEAT_TIME),
            .REPEAT_ON  (REPEAT_MASK[gi])
        ) u_fsm (
            .clk          (clk),
            .rst_n        (rst_n),
            .key_n        (key_n[gi]),
            .press_pulse  (press_pulse[gi]),
            .release_pulse(release_pulse[gi]),
            .long_pulse   (long_pulse[gi]),
            .repeat_pulse (repeat_pulse[gi]),
            .busy         (busy[gi])
        );
    end

    assign key_busy = |busy;

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder (LONG_TIME=10, REPEAT_TIME=4).
// Expected pulses follow from each key's run of low samples; repeat expectations
// depend on whether KEY_REPEAT_EN is defined.
module tb_key_event_decoder;

    localparam int L = 10;
    localparam int R = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] keys = 4'hF;
    logic [3:0] press_pulse, release_pulse, long_pulse, repeat_pulse;
    logic       key_busy;

    typedef struct {
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] lg;
        logic [3:0] rp;
        logic       bz;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    logic [3:0] h1 = 4'hF;
    logic [3:0] h2 = 4'hF;
    int         run_len [4] = '{0, 0, 0, 0};
`ifdef KEY_REPEAT_EN
    logic [3:0] rep_mask = 4'b0100;
`else
    logic [3:0] rep_mask = 4'b0000;
`endif

    key_event_decoder #(
        .LONG_TIME  (L),
        .REPEAT_TIME(R),
        .REPEAT_MASK(4'b0100)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .filter_mode_key  (keys[0]),
        .filter_move_key  (keys[1]),
        .filter_add_key   (keys[2]),
        .filter_switch_key(keys[3]),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .long_pulse       (long_pulse),
        .repeat_pulse     (repeat_pulse),
        .key_busy         (key_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus, push its expected outputs, then compare
    // after the sampling edge.
    task automatic step(input logic [3:0] k, input logic rst);
        exp_t e;
        exp_t got;
        e.pr = '0; e.rl = '0; e.lg = '0; e.rp = '0; e.bz = 1'b0;
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                e.pr[i] = ~h1[i] & h2[i];
                e.rl[i] = h1[i] & ~h2[i];
                e.lg[i] = ~h1[i] && (run_len[i] - 1 == L);
                e.rp[i] = rep_mask[i] && ~h1[i] && (run_len[i] - 1 > L)
                          && (((run_len[i] - 1 - L) % R) == 0);
                if (!h1[i]) e.bz = 1'b1;
            end
        end
        h2 = h1;
        h1 = rst ? 4'hF : k;
        for (int i = 0; i < 4; i++) run_len[i] = h1[i] ? 0 : run_len[i] + 1;
        sb_q.push_back(e);

        keys  = k;
        rst_n = ~rst;
        @(posedge clk);
        #1;
        cyc++;
        got = sb_q.pop_front();
        chk("press",   press_pulse,      got.pr);
        chk("release", release_pulse,    got.rl);
        chk("long",    long_pulse,       got.lg);
        chk("repeat",  repeat_pulse,     got.rp);
        chk("busy",    {3'b0, key_busy}, {3'b0, got.bz});
    endtask

    task automatic hold(input logic [3:0] k, input int n);
        for (int i = 0; i < n; i++) step(k, 1'b0);
    endtask

    initial begin
        logic [3:0] rk;
        logic [3:0] mk;

        hold(4'hF, 0);
        for (int i = 0; i < 3; i++) step(4'hF, 1'b1);
        hold(4'hF, 50);

        hold(4'b1110, 3);   hold(4'hF, 8);     // mode short press
        hold(4'b1101, 20);  hold(4'hF, 5);     // move long, repeat masked
        hold(4'b1011, 30);  hold(4'hF, 5);     // add long with repeats
        hold(4'b1011, L);   hold(4'hF, 5);     // release on long terminal count
        hold(4'b1101, L);   hold(4'hF, 5);
        hold(4'b1011, L + R);     hold(4'hF, 5); // release on first repeat count
        hold(4'b1011, L + 2 * R); hold(4'hF, 5); // release on second repeat count

        // Overlapping holds on all four keys.
        for (int t = 0; t < 30; t++) begin
            mk = 4'hF;
            if (t < 12)           mk[0] = 1'b0;
            if (t < 10)           mk[1] = 1'b0;
            if (t >= 2 && t < 26) mk[2] = 1'b0;
            if (t >= 5 && t < 29) mk[3] = 1'b0;
            step(mk, 1'b0);
        end
        hold(4'hF, 5);

        // Reset mid-hold with switch held through and after reset.
        hold(4'b0111, 15);
        for (int i = 0; i < 3; i++) step(4'b0111, 1'b1);
        hold(4'b0111, 8);
        hold(4'hF, 5);

        // Add key held through reset as well.
        hold(4'b1011, 25);
        for (int i = 0; i < 2; i++) step(4'b1011, 1'b1);
        hold(4'b1011, 20);
        hold(4'hF, 5);

        rk = 4'hF;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 9) == 0) rk[i] = ~rk[i];
            step(rk, 1'b0);
        end
        hold(4'hF, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
